// File: rtl/fifo_pkg.sv
// Shared widths and types for the SPI-side word FIFOs (fpga2host and host2fpga).
package fifo_pkg;

  localparam int FIFO_W         = 32;
  localparam int FIFO_DEPTH_MAX = 512;
  localparam int FIFO_CNT_W     = 10;

  typedef logic [FIFO_W-1:0]     fifo_word_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

  // Occupancy step: a simultaneous push and pop leaves the count unchanged.
  function automatic fifo_cnt_t cnt_step(input fifo_cnt_t cnt,
                                         input logic      inc,
                                         input logic      dec);
    case ({inc, dec})
      2'b10:   return cnt + fifo_cnt_t'(1);
      2'b01:   return cnt - fifo_cnt_t'(1);
      default: return cnt;
    endcase
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port, written
// so synthesis maps it onto block RAM. Read data holds while rd_en is low.
module sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fpga2host_fifo.sv
// FPGA-to-host word FIFO: plain write strobe in, AXIStream master out towards spi_interface.
// Optional peak-occupancy register is built when FPGA2HOST_FIFO_PEAK_EN is defined.
module fpga2host_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_W-1:0]     wr_data,
  output logic                  interf_tvalid,
  input  logic                  interf_tready,
  output logic [FIFO_W-1:0]     interf_tdata,
  output logic [FIFO_CNT_W-1:0] fpga2host_fifo_filled,
  output logic                  err_outfifo_overflow_pulse,
  input  logic                  peak_clr,
  output logic [FIFO_CNT_W-1:0] peak_filled
);

  localparam int            AW        = $clog2(DEPTH);
  localparam fifo_cnt_t     DEPTH_CNT = fifo_cnt_t'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  fifo_cnt_t     count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_valid;
  logic          out_valid;
  fifo_word_t    out_data;
  logic          ovf_pulse;

  logic          full;
  logic          accept;
  logic          drop;
  logic          pop;
  logic          load_out;
  logic          rd_en;
  fifo_cnt_t     ram_words;
  fifo_cnt_t     count_next;
  fifo_word_t    ram_rd_data;

`ifdef FPGA2HOST_FIFO_PEAK_EN
  fifo_cnt_t     peak;
`endif

  sdp_ram #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wptr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rptr),
    .rd_data (ram_rd_data)
  );

  // count covers RAM, the RAM read register and the output register, so words
  // still sitting in the RAM are whatever the two pipeline stages do not hold.
  always_comb begin
    full       = (count == DEPTH_CNT);
    accept     = wr_en && !full;
    drop       = wr_en && full;
    pop        = out_valid && interf_tready;
    load_out   = rd_valid && (!out_valid || pop);
    ram_words  = count - fifo_cnt_t'(rd_valid) - fifo_cnt_t'(out_valid);
    rd_en      = (ram_words != '0) && (!rd_valid || load_out);
    count_next = cnt_step(count, accept, pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      rd_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf_pulse <= 1'b0;
`ifdef FPGA2HOST_FIFO_PEAK_EN
      peak      <= '0;
`endif
    end else begin
      count     <= count_next;
      ovf_pulse <= drop;
      if (accept) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_en) begin
        rptr <= rptr + PTR_ONE;
      end
      // The RAM read register only refills once its word has moved on.
      if (rd_en) begin
        rd_valid <= 1'b1;
      end else if (load_out) begin
        rd_valid <= 1'b0;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= ram_rd_data;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
`ifdef FPGA2HOST_FIFO_PEAK_EN
      if (peak_clr) begin
        peak <= count_next;
      end else if (count_next > peak) begin
        peak <= count_next;
      end
`endif
    end
  end

  assign interf_tvalid              = out_valid;
  assign interf_tdata               = out_data;
  assign fpga2host_fifo_filled      = count;
  assign err_outfifo_overflow_pulse = ovf_pulse;

`ifdef FPGA2HOST_FIFO_PEAK_EN
  assign peak_filled = peak;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_filled     = '0;
`endif

endmodule
